// File: rtl/control_unit_fsm_pkg.sv
// control_unit_fsm_pkg: shared opcode, state, bus-select and ALU codes
// for the control unit, datapath and bench.
package control_unit_fsm_pkg;

    typedef enum logic [3:0] {
        S_IDLE, S_FET1, S_FET2, S_DEC, S_EX1,
        S_RD1, S_RD2, S_WR1, S_WR2, S_BR1, S_BR2, S_HALT
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_NOT  = 4'd4;
    localparam logic [3:0] OP_RD   = 4'd5;
    localparam logic [3:0] OP_WR   = 4'd6;
    localparam logic [3:0] OP_BR   = 4'd7;
    localparam logic [3:0] OP_BRZ  = 4'd8;
    localparam logic [3:0] OP_HALT = 4'd15;

    localparam logic [2:0] SEL1_PC   = 3'd4;
    localparam logic [1:0] SEL2_ALU  = 2'd0;
    localparam logic [1:0] SEL2_BUS1 = 2'd1;
    localparam logic [1:0] SEL2_MEM  = 2'd2;

    localparam logic [1:0] ALU_ADD = 2'd0;
    localparam logic [1:0] ALU_SUB = 2'd1;
    localparam logic [1:0] ALU_AND = 2'd2;
    localparam logic [1:0] ALU_NOT = 2'd3;

endpackage

// File: rtl/control_unit_fsm_decode.sv
// ctrl_decode: classifies an opcode.
//   opcode    in  4  instruction[15:12]
//   is_alu    out 1  ADD/SUB/AND/NOT
//   is_mem    out 1  RD/WR
//   is_branch out 1  BR/BRZ
//   illegal   out 1  opcodes 9..14
module ctrl_decode
    import control_unit_fsm_pkg::*;
(
    input  logic [3:0] opcode,
    output logic       is_alu,
    output logic       is_mem,
    output logic       is_branch,
    output logic       illegal
);

    assign is_alu    = opcode >= OP_ADD && opcode <= OP_NOT;
    assign is_mem    = opcode == OP_RD || opcode == OP_WR;
    assign is_branch = opcode == OP_BR || opcode == OP_BRZ;
    assign illegal   = opcode > OP_BRZ && opcode < OP_HALT;

endmodule

// File: rtl/control_unit_fsm.sv
// control_unit_fsm: fetch/decode/execute sequencer for the 16-bit datapath.
//   clk, rst (async, active-high)
//   instruction[15:0]  IR: [15:12] opcode, [11:10] src, [9:8] dest
//   zero               Reg_Z flag, used by BRZ
//   load_r[3:0], load_pc, inc_pc, load_ir, load_add_r, load_reg_y, load_reg_z,
//   alu_sel, sel_bus_1, sel_bus_2, write  datapath controls
//   halted, err        halt indication and sticky illegal-opcode flag
module control_unit_fsm
    import control_unit_fsm_pkg::*;
#(
    parameter int word_size = 16,
    parameter int op_size   = 4,
    parameter int sel1_size = 3,
    parameter int sel2_size = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [word_size-1:0] instruction,
    input  logic                 zero,
    output logic [3:0]           load_r,
    output logic                 load_pc,
    output logic                 inc_pc,
    output logic                 load_ir,
    output logic                 load_add_r,
    output logic                 load_reg_y,
    output logic                 load_reg_z,
    output logic [1:0]           alu_sel,
    output logic [sel1_size-1:0] sel_bus_1,
    output logic [sel2_size-1:0] sel_bus_2,
    output logic                 write,
    output logic                 halted,
    output logic                 err
);

    state_t state, next;
    logic [op_size-1:0] opcode;
    logic [1:0] src, dest;
    logic is_alu, is_mem, is_branch, illegal;

    assign opcode = instruction[15:12];
    assign src    = instruction[11:10];
    assign dest   = instruction[9:8];

    ctrl_decode u_decode (
        .opcode    (opcode),
        .is_alu    (is_alu),
        .is_mem    (is_mem),
        .is_branch (is_branch),
        .illegal   (illegal)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            err   <= 1'b0;
        end else begin
            state <= next;
            if (state == S_DEC && illegal)
                err <= 1'b1;
        end
    end

    always_comb begin
        next       = state;
        load_r     = 4'b0000;
        load_pc    = 1'b0;
        inc_pc     = 1'b0;
        load_ir    = 1'b0;
        load_add_r = 1'b0;
        load_reg_y = 1'b0;
        load_reg_z = 1'b0;
        alu_sel    = ALU_ADD;
        sel_bus_1  = 3'd0;
        sel_bus_2  = SEL2_BUS1;
        write      = 1'b0;
        halted     = 1'b0;
        case (state)
            S_IDLE: next = S_FET1;
            S_FET1: begin
                sel_bus_1  = SEL1_PC;
                load_add_r = 1'b1;
                next       = S_FET2;
            end
            S_FET2: begin
                sel_bus_2 = SEL2_MEM;
                load_ir   = 1'b1;
                inc_pc    = 1'b1;
                next      = S_DEC;
            end
            S_DEC: begin
                next = S_FET1;
                if (illegal || opcode == OP_HALT) begin
                    next = S_HALT;
                end else if (is_alu) begin
                    sel_bus_1 = {1'b0, src};
                    if (opcode == OP_NOT) begin
                        alu_sel    = ALU_NOT;
                        sel_bus_2  = SEL2_ALU;
                        load_reg_z = 1'b1;
                        load_r     = 4'b0001 << dest;
                    end else begin
                        load_reg_y = 1'b1;
                        next       = S_EX1;
                    end
                end else if (is_mem || (is_branch && (opcode == OP_BR || zero))) begin
                    // operand word lives at PC: start its fetch like FET1
                    sel_bus_1  = SEL1_PC;
                    load_add_r = 1'b1;
                    next = opcode == OP_RD ? S_RD1 : opcode == OP_WR ? S_WR1 : S_BR1;
                end else if (is_branch) begin
                    // BRZ not taken: step PC past the unused target word
                    inc_pc = 1'b1;
                end
            end
            S_EX1: begin
                sel_bus_1  = {1'b0, dest};
                alu_sel    = opcode[1:0] - 2'd1;
                sel_bus_2  = SEL2_ALU;
                load_reg_z = 1'b1;
                load_r     = 4'b0001 << dest;
                next       = S_FET1;
            end
            S_RD1, S_WR1: begin
                sel_bus_2  = SEL2_MEM;
                load_add_r = 1'b1;
                inc_pc     = 1'b1;
                next       = state == S_RD1 ? S_RD2 : S_WR2;
            end
            S_RD2: begin
                sel_bus_2 = SEL2_MEM;
                load_r    = 4'b0001 << dest;
                next      = S_FET1;
            end
            S_WR2: begin
                sel_bus_1 = {1'b0, src};
                write     = 1'b1;
                next      = S_FET1;
            end
            S_BR1: begin
                sel_bus_2  = SEL2_MEM;
                load_add_r = 1'b1;
                next       = S_BR2;
            end
            S_BR2: begin
                sel_bus_2 = SEL2_MEM;
                load_pc   = 1'b1;
                next      = S_FET1;
            end
            S_HALT: halted = 1'b1;
            default: next = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_control_unit_fsm.sv
// tb_control_unit_fsm: randomized and directed checks of control_unit_fsm
// against a per-instruction micro-step model.
module tb_control_unit_fsm;

    typedef struct packed {
        logic [3:0] lr;
        logic       lpc, inc, lir, lar, ly, lz;
        logic [1:0] alu;
        logic [2:0] s1;
        logic [1:0] s2;
        logic       wr, h, e;
    } o_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] instruction = 16'h0000;
    logic        zero = 1'b0;
    logic [3:0]  load_r;
    logic        load_pc, inc_pc, load_ir, load_add_r, load_reg_y, load_reg_z;
    logic [1:0]  alu_sel;
    logic [2:0]  sel_bus_1;
    logic [1:0]  sel_bus_2;
    logic        write, halted, err;
    o_t          dut_o;

    int n_pass = 0;
    int n_tot  = 0;
    logic exp_err = 1'b0;
    o_t q[$];
    o_t got[$];

    control_unit_fsm dut (
        .clk         (clk),
        .rst         (rst),
        .instruction (instruction),
        .zero        (zero),
        .load_r      (load_r),
        .load_pc     (load_pc),
        .inc_pc      (inc_pc),
        .load_ir     (load_ir),
        .load_add_r  (load_add_r),
        .load_reg_y  (load_reg_y),
        .load_reg_z  (load_reg_z),
        .alu_sel     (alu_sel),
        .sel_bus_1   (sel_bus_1),
        .sel_bus_2   (sel_bus_2),
        .write       (write),
        .halted      (halted),
        .err         (err)
    );

    always #5 clk = ~clk;

    assign dut_o = {load_r, load_pc, inc_pc, load_ir, load_add_r, load_reg_y, load_reg_z,
                    alu_sel, sel_bus_1, sel_bus_2, write, halted, err};

    task automatic chk(input string name, input o_t a, input o_t e);
        n_tot++;
        if (a === e) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, a, e, $time);
    endtask

    task automatic lit(input string name, input int a, input int e);
        n_tot++;
        if (a == e) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, a, e);
    endtask

    always @(negedge clk) begin
        if (q.size() != 0) begin
            o_t e;
            e = q.pop_front();
            got.push_back(dut_o);
            chk("cycle", dut_o, e);
        end
    end

    function automatic o_t idle_o();
        o_t d;
        d = '0;
        d.s2 = 2'd1;
        d.e = exp_err;
        return d;
    endfunction

    // Expected output per cycle of one instruction, fetch included.
    task automatic plan(input logic [15:0] ins, input logic z);
        o_t d, x;
        int op;
        logic [1:0] src, dst;
        op = int'(ins[15:12]);
        src = ins[11:10];
        dst = ins[9:8];
        d = idle_o();
        x = d; x.s1 = 3'd4; x.lar = 1'b1; q.push_back(x);
        x = d; x.s2 = 2'd2; x.lir = 1'b1; x.inc = 1'b1; q.push_back(x);
        if (op == 8 && !z) begin
            x = d; x.inc = 1'b1; q.push_back(x);
        end else if (op == 0) begin
            q.push_back(d);
        end else if (op >= 1 && op <= 3) begin
            x = d; x.s1 = {1'b0, src}; x.ly = 1'b1; q.push_back(x);
            x = d; x.s1 = {1'b0, dst}; x.alu = 2'(op - 1); x.s2 = 2'd0; x.lz = 1'b1;
            x.lr = 4'(1 << dst); q.push_back(x);
        end else if (op == 4) begin
            x = d; x.s1 = {1'b0, src}; x.alu = 2'd3; x.s2 = 2'd0; x.lz = 1'b1;
            x.lr = 4'(1 << dst); q.push_back(x);
        end else if (op >= 5 && op <= 8) begin
            x = d; x.s1 = 3'd4; x.lar = 1'b1; q.push_back(x);
            x = d; x.s2 = 2'd2; x.lar = 1'b1; x.inc = (op == 5 || op == 6); q.push_back(x);
            x = d;
            if (op == 5) begin x.s2 = 2'd2; x.lr = 4'(1 << dst); end
            else if (op == 6) begin x.s1 = {1'b0, src}; x.wr = 1'b1; end
            else begin x.s2 = 2'd2; x.lpc = 1'b1; end
            q.push_back(x);
        end else begin
            q.push_back(d);
            if (op != 15) exp_err = 1'b1;
            x = idle_o(); x.h = 1'b1;
            repeat (20) q.push_back(x);
        end
    endtask

    task automatic run(input logic [15:0] ins, input logic z);
        int n;
        @(posedge clk);
        #1;
        instruction = ins;
        zero = z;
        got.delete();
        plan(ins, z);
        n = q.size();
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        o_t d;
        rst = 1'b1;
        exp_err = 1'b0;
        #1;
        chk("in_reset", dut_o, idle_o());
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.push_back(idle_o());
        @(negedge clk);
        #1;
    endtask

    initial begin
        int cnt;
        do_reset();

        run(16'h1600, 1'b0);
        lit("fet1_sel1", int'(got[0].s1), 4);
        lit("fet1_sel2", int'(got[0].s2), 1);
        lit("fet1_lar", int'(got[0].lar), 1);
        lit("add_dec_ly", int'(got[2].ly), 1);
        lit("add_dec_s1", int'(got[2].s1), 1);
        lit("add_ex_alu", int'(got[3].alu), 0);
        lit("add_ex_lr", int'(got[3].lr), 4);

        run(16'h5300, 1'b0);
        lit("rd_c5_lr", int'(got[4].lr), 8);
        lit("rd_c5_s2", int'(got[4].s2), 2);
        cnt = 0;
        foreach (got[i]) cnt += int'(got[i].inc);
        lit("rd_inc_cnt", cnt, 2);

        run(16'h8000, 1'b0);
        lit("brz0_len", got.size(), 3);
        lit("brz0_inc", int'(got[2].inc), 1);
        run(16'h8000, 1'b1);
        lit("brz1_lpc", int'(got[4].lpc), 1);

        for (int i = 0; i < 300; i++) begin
            logic [15:0] ins;
            ins = 16'($urandom);
            ins[15:12] = 4'($urandom_range(0, 8));
            run(ins, 1'($urandom));
        end

        run(16'hF000, 1'b0);
        lit("halt_h", int'(halted), 1);
        lit("halt_err", int'(err), 0);
        do_reset();

        run(16'hA000, 1'b0);
        lit("ill_h", int'(halted), 1);
        lit("ill_err", int'(err), 1);
        lit("ill_strobes", int'({load_r, load_pc, inc_pc, load_ir, load_add_r,
                                 load_reg_y, load_reg_z, write}), 0);
        do_reset();
        lit("rst_err", int'(err), 0);

        for (int i = 9; i <= 14; i++) begin
            logic [15:0] ins;
            ins = 16'($urandom);
            ins[15:12] = 4'(i);
            run(ins, 1'($urandom));
            do_reset();
        end

        run(16'h6C00, 1'b0);
        lit("wr2_write", int'(write), 1);
        rst = 1'b1;
        #1;
        lit("wr2_rst_write", int'(write), 0);
        exp_err = 1'b0;
        chk("wr2_rst_all", dut_o, idle_o());
        do_reset();
        run(16'h0000, 1'b0);
        lit("after_rst_fet1", int'(got[0].s1), 4);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
